uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmitter, the sending end of the serial link whose receiver produces data_valid_rx / p_data_rx. It accepts a parallel byte with a valid strobe from the system side, already synchronized into the TX clock domain. It serializes the byte onto TX_OUT as a frame: start bit, data bits LSB first, optional parity bit, one stop bit. BUSY tells the upstream FIFO read logic when the next word may be presented.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of PRESCALE input

Ports:
UART_CLK  in  1  transmit clock; all logic on its rising edge
RST  in  1  reset; synchronous, active-high
P_DATA  in  DATA_WIDTH  parallel data to send
DATA_VALID  in  1  P_DATA valid; accepted only while BUSY=0
PAR_EN  in  1  1 = insert parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
PRESCALE  in  PRESCALE_W  UART_CLK cycles per serial bit; 0 treated as 1
TX_OUT  out  1  serial line, idle high, registered
BUSY  out  1  frame in progress, registered
TX_DONE  out  1  one-cycle pulse when stop bit completes, registered

Behaviour:
- Reset (RST=1 at a rising edge): state=IDLE, TX_OUT=1, BUSY=0, TX_DONE=0, counters cleared.
  - Reset overrides all other inputs.
  - Reset mid-frame aborts the frame immediately; no partial completion and no TX_DONE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - Acceptance edge is an edge with DATA_VALID=1 in IDLE. On that edge: capture P_DATA, PAR_EN, PAR_TYP and PRESCALE (max(PRESCALE,1)) into shadow registers; compute parity from the captured data; go to START; TX_OUT<=0; BUSY<=1.
- Input changes after acceptance do not affect the frame in flight.
- Bit timing:
  - A prescale counter counts 0..P-1, where P is the captured prescale. Each serial bit is held for exactly P cycles.
  - Transitions occur on the edge where the counter = P-1.
- START: after P cycles go to DATA, bit index=0; TX_OUT<=data[0].
- DATA:
  - Every P cycles the bit index increments and TX_OUT<=data[index].
  - After bit DATA_WIDTH-1 completes: go to PARITY if captured PAR_EN=1, else STOP.
- PARITY:
  - TX_OUT = ^data for even parity; ~^data for odd parity.
  - After P cycles go to STOP.
- STOP:
  - TX_OUT=1 for P cycles.
  - On the final edge: state<=IDLE, BUSY<=0, TX_DONE<=1 for one cycle.
- Latency and frame length:
  - TX_OUT falls on the acceptance edge.
  - BUSY is high for (2+DATA_WIDTH+PAR_EN)*P cycles.
- Handshake:
  - DATA_VALID while BUSY=1 is ignored; no queuing.
  - DATA_VALID held high continuously is accepted on the first IDLE edge after BUSY falls. This gives a minimum 1-cycle idle-high gap between frames.
  - DATA_VALID and the final STOP edge in the same cycle: not accepted on that edge.
- Counter widths:
  - Prescale counter is PRESCALE_W bits; no wrap beyond P-1.
  - Bit index is clog2(DATA_WIDTH) bits and never exceeds DATA_WIDTH-1.
- TX_OUT never glitches: it is driven only from a register.

Test Plan:
- Basic frame: P_DATA=0xA5, PAR_EN=0, PRESCALE=1, DATA_VALID pulse -> TX_OUT=0,1,0,1,0,0,1,0,1,1 on successive cycles; BUSY high exactly 10 cycles; TX_DONE pulses once on the final edge; TX_OUT then stays 1.
- Parity:
  - 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-cycle frame.
  - PAR_TYP=1 -> parity bit 1.
  - 0x07 even -> parity bit 1.
- Prescale: 0x3C, PAR_EN=1, PAR_TYP=0, PRESCALE=4 -> every level held 4 cycles; BUSY high 44 cycles. PRESCALE=0 -> identical to PRESCALE=1.
- Busy handshake:
  - Pulse DATA_VALID with 0x55 at frame cycle 3 of a 0xA5 frame -> ignored; the 0xA5 frame is unchanged and no second frame follows.
  - DATA_VALID held high with 0x12 then 0x34 -> two frames separated by exactly one idle-high cycle.
- Input stability: change P_DATA/PAR_EN/PRESCALE mid-frame -> frame bits and timing still match the values captured at acceptance.
- Reset mid-frame: assert RST during DATA bit 4 of 0xA5 -> next edge TX_OUT=1, BUSY=0, no TX_DONE; next DATA_VALID=0xFF produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Inputs are captured on acceptance; TX_OUT, BUSY and TX_DONE all come straight from flops.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  UART_CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  TX_DONE
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] ONE_P    = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [PRESCALE_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    bit_end;
    logic [IDX_W-1:0]        idx_nxt;

    // presc_q is never zero, so presc_q - 1 cannot underflow
    assign bit_end = (cnt_q == (presc_q - ONE_P));
    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q == IDLE) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (DATA_VALID) begin
                data_d    = P_DATA;
                par_en_d  = PAR_EN;
                par_bit_d = (^P_DATA) ^ PAR_TYP;
                presc_d   = (PRESCALE == '0) ? ONE_P : PRESCALE;
                cnt_d     = '0;
                idx_d     = '0;
                state_d   = START;
                tx_d      = 1'b0;
                busy_d    = 1'b1;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + ONE_P;
        end else begin
            cnt_d = '0;
            case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
                DATA: begin
                    if (idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data_q[idx_nxt];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge UART_CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= ONE_P;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign TX_OUT  = tx_q;
    assign BUSY    = busy_q;
    assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: cycle-by-cycle comparison against a frame-level line model.
module tb_uart_tx_serializer;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] p_data = '0;
    logic          dv = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          tx_out, busy, tx_done;

    int checks   = 0;
    int failures = 0;
    int ndone    = 0;

    // Model: expected line levels still to be shown for the frame in flight.
    logic m_tx   = 1'b1;
    logic m_busy = 1'b0;
    logic m_done = 1'b0;
    bit   m_q[$];

    uart_tx_serializer #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .UART_CLK  (clk),
        .RST       (rst),
        .P_DATA    (p_data),
        .DATA_VALID(dv),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .PRESCALE  (prescale),
        .TX_OUT    (tx_out),
        .BUSY      (busy),
        .TX_DONE   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        int p;
        bit lv[$];
        if (rst) begin
            m_q.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_busy) begin
            m_done = 1'b0;
            if (m_q.size() > 0) begin
                m_tx = m_q.pop_front();
            end else begin
                m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            m_tx   = 1'b1;
            if (dv) begin
                p = (prescale == 0) ? 1 : int'(prescale);
                lv.push_back(1'b0);
                for (int i = 0; i < DW; i++) lv.push_back(p_data[i]);
                if (par_en) begin
                    if (par_typ) lv.push_back(($countones(p_data) % 2) == 0);
                    else         lv.push_back(($countones(p_data) % 2) == 1);
                end
                lv.push_back(1'b1);
                foreach (lv[i]) repeat (p) m_q.push_back(lv[i]);
                m_tx   = m_q.pop_front();
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_bit("tx_out", tx_out, m_tx);
        check_bit("busy", busy, m_busy);
        check_bit("tx_done", tx_done, m_done);
        if (tx_done === 1'b1) ndone++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // mode 0: quiet inputs, 1: scramble inputs while busy, 2: pulse 0x55 on cycle 3
    task automatic frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                         input logic [PW-1:0] ps, input int mode);
        int len, exp_len, nd0;
        p_data = d; par_en = pe; par_typ = pt; prescale = ps; dv = 1'b1;
        nd0     = ndone;
        exp_len = (2 + DW + int'(pe)) * ((ps == 0) ? 1 : int'(ps));
        tick();
        dv  = 1'b0;
        len = (busy === 1'b1) ? 1 : 0;
        while (busy === 1'b1 && len < 1000) begin
            if (mode == 1) begin
                p_data = DW'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
                prescale = PW'($urandom); dv = 1'($urandom);
            end else if (mode == 2) begin
                dv = (len == 3); p_data = (len == 3) ? 8'h55 : d;
            end
            tick();
            if (busy === 1'b1) len++;
        end
        dv = 1'b0;
        check_int("busy_len", len, exp_len);
        check_int("done_count", ndone - nd0, 1);
        tick();
    endtask

    initial begin
        int nd0, n;

        idle(2);
        rst = 1'b0;
        idle(2);

        frame(8'hA5, 1'b0, 1'b0, 6'd1, 0);
        idle(3);
        frame(8'hA5, 1'b1, 1'b0, 6'd1, 0);
        frame(8'hA5, 1'b1, 1'b1, 6'd1, 0);
        frame(8'h07, 1'b1, 1'b0, 6'd1, 0);
        frame(8'h3C, 1'b1, 1'b0, 6'd4, 0);
        frame(8'hA5, 1'b0, 1'b0, 6'd0, 0);

        // request during a frame is dropped, nothing follows
        nd0 = ndone;
        frame(8'hA5, 1'b0, 1'b0, 6'd1, 2);
        idle(12);
        check_int("ignored_frames", ndone - nd0, 1);

        // held DATA_VALID: two back-to-back frames with one idle cycle between
        p_data = 8'h12; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd1; dv = 1'b1;
        nd0 = ndone;
        tick();
        p_data = 8'h34;
        n = 0;
        while ((ndone - nd0) < 2 && n < 100) begin
            tick();
            n++;
        end
        dv = 1'b0;
        check_int("held_frames", ndone - nd0, 2);
        check_int("held_cycles", n, 21);
        idle(3);

        // mid-frame input changes
        frame(8'h3C, 1'b1, 1'b0, 6'd3, 1);

        // reset during data bit 4
        p_data = 8'hA5; par_en = 1'b0; prescale = 6'd1; dv = 1'b1;
        tick();
        dv = 1'b0;
        idle(5);
        nd0 = ndone;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("rst_tx", tx_out, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        idle(12);
        check_int("rst_no_done", ndone - nd0, 0);
        frame(8'hFF, 1'b0, 1'b0, 6'd1, 0);

        for (int i = 0; i < 25; i++) begin
            frame(DW'($urandom), 1'($urandom), 1'($urandom),
                  PW'($urandom_range(0, 5)), int'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
